keypad_scanner_param: RTL and testbench

Parametrised matrix-keypad scanner for N_ROWS x N_COLS keypads, generalising the fixed 4x4 scan/debounce path.
- Drives a one-hot column strobe at a programmable scan rate and synchronises the row inputs.
- Debounces both press and release through an explicit FSM.
- Encodes the pressed key as a raw index and queues it in a small FIFO with a valid/ready handshake.
- Sits between the keypad pins and the key-to-hex decode / consumer logic.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_fifo.sv | 62 ++++++
 rtl/keypad_scanner_param.sv | 132 +++++++++++++
 tb/tb_keypad_scanner_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the parametrised keypad scanner.
// Row and column counts are limited to 8 so helpers can use a fixed-width vector.
package keypad_pkg;

  localparam int MAX_LINES = 8;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } scan_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_bit_idx(input logic [MAX_LINES-1:0] v);
    lowest_bit_idx = '0;
    for (int i = MAX_LINES - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit_idx = 3'(i);
    end
  endfunction

  function automatic int key_index(input int col_idx, input int row_idx, input int n_rows);
    return col_idx * n_rows + row_idx;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small key-code queue with registered head outputs (dout/valid).
// Depth is a power of two so the pointers wrap naturally.
module keypad_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [AW:0]      count, count_next;
  logic             full, do_push, do_pop;
  logic [WIDTH-1:0] head_next;

  // Valid/ready: an entry leaves when valid && pop on a rising clock edge.
  // A push into a full queue is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop     = pop && valid;
    full       = (count == (AW+1)'(DEPTH));
    do_push    = push && (!full || do_pop);
    drop       = push && full && !do_pop;
    rd_next    = rd_ptr + AW'(do_pop);
    count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_next  = dout;
    if (count_next != '0) begin
      // When nothing older remains, the entry being written becomes the head.
      if (do_push && ((count - (AW+1)'(do_pop)) == '0)) head_next = din;
      else                                             head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      dout   <= head_next;
      valid  <= (count_next != '0);
    end
  end

endmodule

// File: rtl/keypad_scanner_param.sv
// N_ROWS x N_COLS matrix keypad scanner: column strobe, row synchroniser,
// press/release debounce FSM and a key-code FIFO towards the consumer.
module keypad_scanner_param
  import keypad_pkg::*;
#(
  parameter int N_ROWS          = 4,
  parameter int N_COLS          = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int FIFO_DEPTH      = 4,
  localparam int KW             = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] fila,
  output logic [N_COLS-1:0] col,
  output logic [KW-1:0]     key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_down,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int CW   = $clog2(N_COLS);
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   COL_LAST = CW'(N_COLS - 1);

  logic [N_ROWS-1:0]    fila_m, rows_s, pat;
  scan_state_t          state;
  logic [DIVW-1:0]      div_cnt;
  logic [CW-1:0]        col_idx, col_next;
  logic [DBW-1:0]       db_cnt;
  logic [MAX_LINES-1:0] pat_w;
  logic [2:0]           row_idx;
  logic                 push, drop;
  logic [KW-1:0]        push_code;

  assign col      = N_COLS'(1) << col_idx;
  assign col_next = (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);

  assign pat_w     = MAX_LINES'(pat);
  assign row_idx   = lowest_bit_idx(pat_w);
  assign push_code = KW'(key_index(32'(col_idx), 32'(row_idx), N_ROWS));
  assign push      = (state == PRESS_DB) && (rows_s == pat) && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      fila_m   <= '0;
      rows_s   <= '0;
      state    <= SCAN;
      div_cnt  <= '0;
      col_idx  <= '0;
      db_cnt   <= '0;
      pat      <= '0;
      key_down <= 1'b0;
    end else begin
      fila_m <= fila;
      rows_s <= fila_m;
      case (state)
        SCAN: begin
          // A row hit wins over a column advance so the captured column matches the hit.
          if (rows_s != '0) begin
            pat    <= rows_s;
            db_cnt <= '0;
            state  <= PRESS_DB;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            col_idx <= col_next;
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        PRESS_DB: begin
          if (rows_s != pat) begin
            state   <= SCAN;
            div_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state    <= HELD;
            key_down <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DBW'(1);
          end
        end
        HELD: begin
          if (rows_s == '0) begin
            db_cnt <= '0;
            state  <= REL_DB;
          end
        end
        REL_DB: begin
          // A row reappearing during release is bounce on the same key: no new push.
          if (rows_s != '0) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state    <= SCAN;
            key_down <= 1'b0;
            col_idx  <= col_next;
            div_cnt  <= '0;
          end else begin
            db_cnt <= db_cnt + DBW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  keypad_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_code),
    .pop   (key_ready),
    .dout  (key_code),
    .valid (key_valid),
    .drop  (drop)
  );

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Bench for keypad_scanner_param: a keypad model gates held rows by the driven column,
// and a code queue plus overflow flag predict what the consumer side must see.
module tb_keypad_scanner_param;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int FD = 4;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst, key_ready, clr_ovf;
  logic [NR-1:0] fila;
  logic [NC-1:0] col;
  logic [KW-1:0] key_code;
  logic          key_valid, key_down, overflow;

  logic          held;
  int            key_c;
  logic [NR-1:0] key_rows;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [KW-1:0] exp_q[$];
  logic          exp_ovf;

  always #5 clk = ~clk;

  // Physical keypad: a held key connects its row(s) to its column line.
  always_comb begin
    fila = '0;
    if (held && ((col & (NC'(1) << key_c)) != '0)) fila = key_rows;
  end

  keypad_scanner_param #(
    .N_ROWS          (NR),
    .N_COLS          (NC),
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DB),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fila      (fila),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] ref_code(input int c, input logic [NR-1:0] rows);
    int r;
    r = 0;
    for (int i = NR - 1; i >= 0; i--) if (rows[i]) r = i;
    return KW'(c * NR + r);
  endfunction

  task automatic model_push(input logic [KW-1:0] code);
    if (exp_q.size() < FD) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  // Wait for the negedge right after the target column becomes driven.
  task automatic wait_col(input int c);
    logic [NC-1:0] prev;
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      prev = col;
      @(negedge clk);
      if (col == (NC'(1) << c) && prev != col) found = 1;
    end
    check("wait_col", 32'(found), 1);
  endtask

  task automatic wait_down(input logic val, input int bound);
    bit found;
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (key_down === val) found = 1;
    end
    check(val ? "wait_key_down_rise" : "wait_key_down_fall", 32'(found), 1);
  endtask

  task automatic press(input int c, input logic [NR-1:0] rows, input int hold);
    key_c    = c;
    key_rows = rows;
    wait_col(c);
    held = 1'b1;
    wait_down(1'b1, 40);
    model_push(ref_code(c, rows));
    repeat (hold) @(negedge clk);
    held = 1'b0;
    wait_down(1'b0, 40);
  endtask

  task automatic pop_one();
    check("pop_valid", 32'(key_valid), 1);
    check("pop_code", 32'(key_code), 32'(exp_q[0]));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
    check("empty_after_drain", 32'(key_valid), 0);
  endtask

  task automatic clear_overflow();
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    check("overflow_cleared", 32'(overflow), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] new_code;
    int            c;
    logic [NR-1:0] rows;

    rst = 1'b1; key_ready = 1'b0; clr_ovf = 1'b0;
    held = 1'b0; key_c = 0; key_rows = '0; exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 1);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_code", 32'(key_code), 0);
    check("rst_key_down", 32'(key_down), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;

    // 1: idle scan, each column held SD cycles
    for (int k = 0; k <= 16; k++) begin
      check("scan_col", 32'(col), 32'(1 << ((k / SD) % NC)));
      @(negedge clk);
    end
    check("scan_key_valid", 32'(key_valid), 0);
    check("scan_overflow", 32'(overflow), 0);

    // 2: clean press in column 2, row 2; latency measured from the column edge
    key_c = 2; key_rows = 4'b0100;
    wait_col(2);
    held = 1'b1;
    repeat (DB + 2) @(negedge clk);
    check("lat_valid_early", 32'(key_valid), 0);
    check("lat_down_early", 32'(key_down), 0);
    @(negedge clk);
    check("lat_valid", 32'(key_valid), 1);
    check("lat_code", 32'(key_code), 32'(ref_code(2, 4'b0100)));
    check("lat_down", 32'(key_down), 1);
    model_push(ref_code(2, 4'b0100));
    repeat (39) @(negedge clk);
    check("held_down", 32'(key_down), 1);
    held = 1'b0;
    // release: 2 sync cycles, 1 cycle to see quiet rows, DB quiet cycles
    repeat (DB + 2) @(negedge clk);
    check("release_down_late", 32'(key_down), 1);
    @(negedge clk);
    check("release_down_fall", 32'(key_down), 0);
    drain();

    // 3: bouncing press, then stable press, then bouncing release
    key_c = 1; key_rows = 4'b0001;
    wait_col(1);
    for (int i = 0; i < 10; i++) begin
      held = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce_no_push", 32'(key_valid), 0);
    check("bounce_no_down", 32'(key_down), 0);
    held = 1'b1;
    wait_down(1'b1, 60);
    model_push(ref_code(1, 4'b0001));
    check("bounce_valid", 32'(key_valid), 1);
    check("bounce_code", 32'(key_code), 32'(ref_code(1, 4'b0001)));
    repeat (5) @(negedge clk);
    held = 1'b0; repeat (5) @(negedge clk);
    held = 1'b1; repeat (2) @(negedge clk);
    held = 1'b0; repeat (8) @(negedge clk);
    repeat (20) @(negedge clk);
    check("rel_bounce_down", 32'(key_down), 0);
    drain();

    // 4: five presses with no consumer
    press(0, 4'b0001, 3);
    press(1, 4'b0010, 3);
    press(2, 4'b0100, 3);
    press(3, 4'b1000, 3);
    press(0, 4'b0010, 3);
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("ovf_model", 32'(exp_ovf), 1);
    drain();
    check("ovf_sticky", 32'(overflow), 1);
    clear_overflow();

    // 5: push into full FIFO while the consumer pops in the same cycle
    for (int i = 0; i < FD; i++) press($urandom_range(0, NC - 1), NR'($urandom_range(1, 15)), 2);
    c = $urandom_range(0, NC - 1);
    rows = NR'($urandom_range(1, 15));
    new_code = ref_code(c, rows);
    key_c = c; key_rows = rows;
    wait_col(c);
    held = 1'b1;
    repeat (DB + 2) @(negedge clk);
    check("full_head_code", 32'(key_code), 32'(exp_q[0]));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(new_code);
    check("full_pop_push_down", 32'(key_down), 1);
    check("full_pop_push_no_ovf", 32'(overflow), 0);
    held = 1'b0;
    wait_down(1'b0, 40);
    drain();

    // 6: reset while HELD with two entries queued, key still held afterwards
    press($urandom_range(0, NC - 1), NR'($urandom_range(1, 15)), 2);
    c = $urandom_range(0, NC - 1);
    rows = NR'($urandom_range(1, 15));
    key_c = c; key_rows = rows;
    wait_col(c);
    held = 1'b1;
    wait_down(1'b1, 40);
    model_push(ref_code(c, rows));
    check("pre_rst_valid", 32'(key_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(key_valid), 0);
    check("mid_rst_down", 32'(key_down), 0);
    check("mid_rst_col", 32'(col), 1);
    check("mid_rst_code", 32'(key_code), 0);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    wait_down(1'b1, 60);
    model_push(ref_code(c, rows));
    check("post_rst_valid", 32'(key_valid), 1);
    check("post_rst_code", 32'(key_code), 32'(ref_code(c, rows)));
    held = 1'b0;
    wait_down(1'b0, 40);
    drain();

    // random presses, multi-row patterns, occasional consumer drains
    for (int n = 0; n < 10; n++) begin
      press($urandom_range(0, NC - 1), NR'($urandom_range(1, 15)), $urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) drain();
    end
    check("rand_overflow", 32'(overflow), 32'(exp_ovf));
    drain();
    clear_overflow();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
